seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter RST_PAT, default 2'b10, giving the pattern loaded at reset (N bits).
REQ-003 The block SHALL have parameter OVERLAP, default 1, where 1 = overlapping matches permitted and 0 = history restarts after each match.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of the match counter.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-007 The block SHALL have port in, input, 1 bit, the serial data sample.
REQ-008 The block SHALL have port in_valid, input, 1 bit; in is consumed only on cycles where it is 1.
REQ-009 The block SHALL have port cfg_load, input, 1 bit, a strobe that loads cfg_pattern.
REQ-010 The block SHALL have port cfg_pattern, input, N bits; bit N-1 = first bit of the sequence, bit 0 = last.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit, a synchronous clear of match_cnt.
REQ-012 The block SHALL have port z, output, 1 bit, the registered match pulse.
REQ-013 The block SHALL have port match_cnt, output, CNT_W bits, a saturating count of matches.

Function
REQ-014 The block SHALL hold an N-bit history register hist, a fill counter fill (0..N), and a pattern register pat.
REQ-015 The block SHALL, on a clock edge with in_valid=1 and cfg_load=0, update hist to {hist[N-2:0], in} and fill to min(fill+1, N).
REQ-016 The block SHALL define a match as (updated hist == pat) AND (updated fill == N), evaluated on the same edge.
REQ-017 The block SHALL register z from the match, so that z=1 for exactly one cycle, in the cycle following the edge that consumed the completing sample; the latency is 1 cycle.
REQ-018 The block SHALL drive z to 0 on any edge with in_valid=0, leaving hist and fill unchanged.
REQ-019 The block SHALL, when OVERLAP=1 and a match occurs, leave hist and fill as updated, so trailing bits may begin the next match.
REQ-020 The block SHALL, when OVERLAP=0 and a match occurs, force fill to 0 on that edge; N further valid samples are then required before the next match.
REQ-021 The block SHALL, on an edge with cfg_load=1, load pat from cfg_pattern and set fill to 0 and z to 0; the in sample on that edge is discarded regardless of in_valid.
REQ-022 The block SHALL increment match_cnt by 1 on each match and saturate it at 2^CNT_W-1, with no wrap.
REQ-023 The block SHALL, on an edge with cnt_clr=1, set match_cnt to 0; if a match occurs on the same edge, clear wins (result 0) while z still pulses.
REQ-024 The block SHALL treat an all-zeros or all-ones pattern as legal; with OVERLAP=1 a constant stream then matches on every valid sample once fill=N.

Reset
REQ-025 The block SHALL, while rst=0, immediately force z=0, match_cnt=0, hist=0, fill=0 and pat=RST_PAT, independent of clk.
REQ-026 The block SHALL, on assertion of reset mid-sequence, discard all partial history; detection resumes from fill=0 on the first valid sample after rst returns to 1.

Structure
REQ-027 The block SHALL take from a shared package seq_det_pkg the constants for the default N, RST_PAT and CNT_W, and the legal-range limits for N.
REQ-028 The block SHALL implement the saturating counter as one sub-module sat_counter (params W; ports clk, rst, inc, clr, q), instantiated once for match_cnt.
REQ-029 The block SHALL keep the history/fill/match logic and the z register in the top module; no further sub-modules.

Verification
REQ-030 The bench SHALL drive N=2, RST_PAT=10, OVERLAP=1 with valid stream 1,1,0,1,0,0,1,0 and require z pulses after samples 3, 5 and 8, and match_cnt=3.
REQ-031 The bench SHALL drive N=3, cfg_pattern=101 with stream 1,0,1,0,1 and require 2 matches (samples 3, 5) with OVERLAP=1, and 1 match (sample 3) with OVERLAP=0.
REQ-032 The bench SHALL drive CNT_W=2 with 5 matches and require match_cnt to stay at 3; cnt_clr asserted together with a match then gives match_cnt=0 and z=1.
REQ-033 The bench SHALL drive stream 1,0 with an in_valid=0 gap of 3 cycles between the two bits and require z to pulse once after the 0 is consumed and stay 0 during the gap.
REQ-034 The bench SHALL assert rst low between the 1 and the 0 of pattern 10 and require z=0, match_cnt=0, and no match after release until a fresh 1,0 arrives.
REQ-035 The bench SHALL assert cfg_load (pattern 11) mid-stream and require no match until two new valid 1s arrive after the load edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared defaults and limits for the
// parameterised serial sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_N     = 2;
  localparam logic [1:0]  DEF_RST_PAT = 2'b10;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned N_MIN     = 2;
  localparam int unsigned N_MAX     = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous
// clear; clear has priority over increment.
import seq_det_pkg::*;

module sat_counter #(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next count: clear, saturating increment or hold
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with loadable pattern,
// optional overlap and saturating match counter.
import seq_det_pkg::*;

module seq_detect_param #(
  parameter int unsigned       N       = DEF_N,
  parameter logic [N-1:0]      RST_PAT = N'(DEF_RST_PAT),
  parameter bit                OVERLAP = 1'b1,
  parameter int unsigned       CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cnt_clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [N-1:0]  pat_q, pat_d;
  logic          z_q, z_d;
  logic          match;

  // shift history, track fill, detect match
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    z_d    = 1'b0;
    match  = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = {hist_q[N-2:0], in};
      if (fill_q != FULL) begin
        fill_d = fill_q + 1'b1;
      end
      match = (hist_d == pat_q) &&
              (fill_d == FULL);
      z_d = match;
      if (match && !OVERLAP) begin
        fill_d = '0;
      end
    end
  end

  // detector state and registered match pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      z_q    <= z_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(match),
    .clr(cnt_clr),
    .q  (match_cnt)
  );

  assign z = z_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param across
// several parameter sets sharing one stimulus.
module tb_seq_detect_param;

  logic       clk;
  logic       rst;
  logic       din;
  logic       in_valid;
  logic       cfg_load;
  logic [1:0] cfg_pat2;
  logic [2:0] cfg_pat3;
  logic       cnt_clr;

  logic       z2, z3o, z3n, zc;
  logic [7:0] cnt2, cnt3o, cnt3n;
  logic [1:0] cntc;

  int checks;
  int failures;

  seq_detect_param #(
    .N(2), .RST_PAT(2'b10),
    .OVERLAP(1'b1), .CNT_W(8)
  ) u2 (
    .clk(clk), .rst(rst), .in(din),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat2), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(cnt2)
  );

  seq_detect_param #(
    .N(3), .RST_PAT(3'b000),
    .OVERLAP(1'b1), .CNT_W(8)
  ) u3o (
    .clk(clk), .rst(rst), .in(din),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat3), .cnt_clr(cnt_clr),
    .z(z3o), .match_cnt(cnt3o)
  );

  seq_detect_param #(
    .N(3), .RST_PAT(3'b000),
    .OVERLAP(1'b0), .CNT_W(8)
  ) u3n (
    .clk(clk), .rst(rst), .in(din),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat3), .cnt_clr(cnt_clr),
    .z(z3n), .match_cnt(cnt3n)
  );

  seq_detect_param #(
    .N(2), .RST_PAT(2'b10),
    .OVERLAP(1'b1), .CNT_W(2)
  ) uc (
    .clk(clk), .rst(rst), .in(din),
    .in_valid(in_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pat2), .cnt_clr(cnt_clr),
    .z(zc), .match_cnt(cntc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push(input logic b,
                      input logic clr);
    @(negedge clk);
    din      = b;
    in_valid = 1'b1;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] p2,
                      input logic [2:0] p3,
                      input logic b);
    @(negedge clk);
    cfg_load = 1'b1;
    cfg_pat2 = p2;
    cfg_pat3 = p3;
    din      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (z2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_z: got %b want 0", z2);
    end
    checks++;
    if (cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d want 0",
               cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] s;
    logic [7:0] e;
    s = 8'b1101_0010;
    e = 8'b0010_1001;
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      push(s[i], 1'b0);
      checks++;
      if (z2 !== e[i]) begin
        failures++;
        $display("FAIL basic_z s%0d: got %b want %b",
                 8 - i, z2, e[i]);
      end
    end
    checks++;
    if (cnt2 !== 8'd3) begin
      failures++;
      $display("FAIL basic_cnt: got %0d want 3",
               cnt2);
    end
  endtask

  task automatic test_overlap();
    logic [4:0] s;
    logic [4:0] eo;
    logic [4:0] en;
    s  = 5'b10101;
    eo = 5'b00101;
    en = 5'b00100;
    do_reset();
    load(2'b10, 3'b101, 1'b0);
    for (int i = 4; i >= 0; i--) begin
      push(s[i], 1'b0);
      checks++;
      if (z3o !== eo[i]) begin
        failures++;
        $display("FAIL ovl1_z s%0d: got %b want %b",
                 5 - i, z3o, eo[i]);
      end
      checks++;
      if (z3n !== en[i]) begin
        failures++;
        $display("FAIL ovl0_z s%0d: got %b want %b",
                 5 - i, z3n, en[i]);
      end
    end
    checks++;
    if (cnt3o !== 8'd2) begin
      failures++;
      $display("FAIL ovl1_cnt: got %0d want 2",
               cnt3o);
    end
    checks++;
    if (cnt3n !== 8'd1) begin
      failures++;
      $display("FAIL ovl0_cnt: got %0d want 1",
               cnt3n);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b1, 1'b0);
      push(1'b0, 1'b0);
    end
    checks++;
    if (cntc !== 2'd3) begin
      failures++;
      $display("FAIL sat_cnt: got %0d want 3", cntc);
    end
    push(1'b1, 1'b0);
    push(1'b0, 1'b1);
    checks++;
    if (zc !== 1'b1) begin
      failures++;
      $display("FAIL clr_z: got %b want 1", zc);
    end
    checks++;
    if (cntc !== 2'd0) begin
      failures++;
      $display("FAIL clr_cnt: got %0d want 0", cntc);
    end
    checks++;
    if (cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL clr_cnt8: got %0d want 0", cnt2);
    end
  endtask

  task automatic test_gap();
    do_reset();
    push(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (z2 !== 1'b0) begin
        failures++;
        $display("FAIL gap_z c%0d: got %b want 0",
                 i, z2);
      end
    end
    push(1'b0, 1'b0);
    checks++;
    if (z2 !== 1'b1) begin
      failures++;
      $display("FAIL gap_match: got %b want 1", z2);
    end
    idle();
    checks++;
    if (z2 !== 1'b0) begin
      failures++;
      $display("FAIL gap_pulse: got %b want 0", z2);
    end
    checks++;
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL gap_cnt: got %0d want 1", cnt2);
    end
  endtask

  task automatic test_reset_mid();
    push(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (z2 !== 1'b0 || cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL rmid_state: got z=%b cnt=%0d want 0/0",
               z2, cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
    push(1'b0, 1'b0);
    checks++;
    if (z2 !== 1'b0) begin
      failures++;
      $display("FAIL rmid_stale: got %b want 0", z2);
    end
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
    checks++;
    if (z2 !== 1'b1) begin
      failures++;
      $display("FAIL rmid_fresh: got %b want 1", z2);
    end
  endtask

  task automatic test_cfg_mid();
    do_reset();
    push(1'b1, 1'b0);
    load(2'b11, 3'b111, 1'b1);
    checks++;
    if (z2 !== 1'b0) begin
      failures++;
      $display("FAIL cfg_loadz: got %b want 0", z2);
    end
    push(1'b1, 1'b0);
    checks++;
    if (z2 !== 1'b0) begin
      failures++;
      $display("FAIL cfg_first: got %b want 0", z2);
    end
    push(1'b1, 1'b0);
    checks++;
    if (z2 !== 1'b1) begin
      failures++;
      $display("FAIL cfg_second: got %b want 1", z2);
    end
    push(1'b1, 1'b0);
    checks++;
    if (z2 !== 1'b1) begin
      failures++;
      $display("FAIL cfg_const: got %b want 1", z2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    din      = 1'b0;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cfg_pat2 = 2'b10;
    cfg_pat3 = 3'b101;
    cnt_clr  = 1'b0;
    test_reset();
    test_basic();
    test_overlap();
    test_saturate();
    test_gap();
    test_reset_mid();
    test_cfg_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
